// File: rtl/sr_drive_sequencer.sv
// Command sequencer for an SR flip-flop: turns set/reset/toggle/hold requests into timed S/R pulses.
// Optional feedback check of q after each command: define SR_DRV_VERIFY_EN.
module sr_drive_sequencer #(
   parameter int PULSE_CYCLES  = 2,
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   input  logic [1:0]       req_op,
   output logic             req_ready,
   input  logic             q_fb,
   output logic             S,
   output logic             R,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] op_count
);
   typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, DONE} state_t;

   localparam logic [1:0] OP_HOLD   = 2'b00;
   localparam logic [1:0] OP_SET    = 2'b01;
   localparam logic [1:0] OP_RESET  = 2'b10;
   localparam logic [1:0] OP_TOGGLE = 2'b11;

   localparam logic [15:0] PULSE_LAST  = 16'(PULSE_CYCLES - 1);
   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

   state_t      state;
   logic [15:0] cnt;
`ifdef SR_DRV_VERIFY_EN
   logic        exp_q;
`endif

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         S        <= 1'b0;
         R        <= 1'b0;
         done     <= 1'b0;
         op_count <= '0;
`ifdef SR_DRV_VERIFY_EN
         exp_q    <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  cnt <= '0;
`ifdef SR_DRV_VERIFY_EN
                  unique case (req_op)
                     OP_HOLD:   exp_q <= q_fb;
                     OP_SET:    exp_q <= 1'b1;
                     OP_RESET:  exp_q <= 1'b0;
                     OP_TOGGLE: exp_q <= ~q_fb;
                     default:   exp_q <= q_fb;
                  endcase
`endif
                  if (req_op == OP_HOLD) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     // Toggle resolves against q at accept; S and R are never both chosen.
                     state <= DRIVE;
                     S     <= (req_op == OP_SET)   | ((req_op == OP_TOGGLE) & ~q_fb);
                     R     <= (req_op == OP_RESET) | ((req_op == OP_TOGGLE) &  q_fb);
                  end
               end
            end
            DRIVE: begin
               if (cnt == PULSE_LAST) begin
                  S   <= 1'b0;
                  R   <= 1'b0;
                  cnt <= '0;
                  if (SETTLE_CYCLES == 0) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     op_count <= op_count + 1'b1;
                  end else begin
                     state <= SETTLE;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            SETTLE: begin
               if (cnt == SETTLE_LAST) begin
                  cnt      <= '0;
                  state    <= DONE;
                  done     <= 1'b1;
                  op_count <= op_count + 1'b1;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SR_DRV_VERIFY_EN
   // Compared live during the DONE cycle so err lines up with done.
   assign err = (state == DONE) & (q_fb != exp_q);
`else
   assign err = 1'b0;
`endif
endmodule

// File: tb/tb_sr_drive_sequencer.sv
// Randomized bench for sr_drive_sequencer with a per-command timeline model and directed literal checks.
module tb_sr_drive_sequencer;
   localparam int P  = 2;
   localparam int SC = 1;
   localparam int CW = 3;
`ifdef SR_DRV_VERIFY_EN
   localparam bit VERIFY = 1'b1;
`else
   localparam bit VERIFY = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic [1:0]    req_op;
   logic          req_ready;
   logic          q_fb;
   logic          S, R, busy, done, err;
   logic [CW-1:0] op_count;

   sr_drive_sequencer #(.PULSE_CYCLES(P), .SETTLE_CYCLES(SC), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_ready(req_ready),
      .q_fb(q_fb), .S(S), .R(R), .busy(busy), .done(done), .err(err), .op_count(op_count)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Model: one active command described by its age t (1 = first cycle after accept) and length.
   bit m_act = 0;
   int m_t = 0, m_len = 0, m_cnt = 0;
   bit m_s = 0, m_r = 0, m_exp = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_act = 0;
         m_cnt = 0;
      end else if (m_act) begin
         if (m_t == m_len) m_act = 0;
         else begin
            m_t++;
            if (m_t == m_len) m_cnt = (m_cnt + 1) % (1 << CW);
         end
      end else if (req_valid) begin
         m_act = 1;
         m_t   = 1;
         m_len = (req_op == 2'd0) ? 1 : P + SC + 1;
         case (req_op)
            2'd0: begin m_s = 0; m_r = 0; m_exp = q_fb; end
            2'd1: begin m_s = 1; m_r = 0; m_exp = 1; end
            2'd2: begin m_s = 0; m_r = 1; m_exp = 0; end
            default: begin m_s = !q_fb; m_r = q_fb; m_exp = !q_fb; end
         endcase
      end
   end

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic check_all();
      bit e_done;
      e_done = m_act && (m_t == m_len);
      cmp("S",         S,         m_act && m_t <= P && m_s);
      cmp("R",         R,         m_act && m_t <= P && m_r);
      cmp("done",      done,      e_done);
      cmp("busy",      busy,      m_act);
      cmp("req_ready", req_ready, !m_act);
      cmp("err",       err,       VERIFY && e_done && (q_fb != m_exp));
      cmp("op_count",  op_count,  m_cnt);
      cmp("s_and_r",   S & R,     0);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   int n;

   initial begin
      rst = 1; req_valid = 0; req_op = 0; q_fb = 0;
      // Reset held 3 cycles
      repeat (3) step();
      rst = 0;
      step();
      cmp("rst_S", S, 0); cmp("rst_R", R, 0); cmp("rst_done", done, 0);
      cmp("rst_cnt", op_count, 0); cmp("rst_ready", req_ready, 1); cmp("rst_busy", busy, 0);

      // Set, q follows from cycle 2
      req_valid = 1; req_op = 2'd1; q_fb = 0;
      step(); cmp("set_c1_S", S, 1);
      req_valid = 0; q_fb = 1;
      step(); cmp("set_c2_S", S, 1);
      step(); cmp("set_c3_S", S, 0); cmp("set_c3_busy", busy, 1);
      step(); cmp("set_c4_done", done, 1); cmp("set_c4_cnt", op_count, 1); cmp("set_c4_err", err, 0);
      step(); cmp("set_c5_ready", req_ready, 1);

      // Toggle with q=1 resolves to R; q stays 1 so verify flags it
      req_valid = 1; req_op = 2'd3; q_fb = 1;
      step(); cmp("tog_c1_R", R, 1); cmp("tog_c1_S", S, 0);
      req_valid = 0;
      step(); cmp("tog_c2_R", R, 1);
      step(); cmp("tog_c3_R", R, 0);
      step(); cmp("tog_c4_done", done, 1); cmp("tog_c4_err", err, VERIFY ? 1 : 0);
      cmp("tog_c4_cnt", op_count, 2);
      step();

      // Hold
      req_valid = 1; req_op = 2'd0;
      step(); cmp("hold_done", done, 1); cmp("hold_S", S, 0); cmp("hold_R", R, 0);
      cmp("hold_cnt", op_count, 2);
      req_valid = 0;
      step(); cmp("hold_ready", req_ready, 1);

      // Reset during second DRIVE cycle
      req_valid = 1; req_op = 2'd1; q_fb = 0;
      step();
      req_valid = 0;
      step(); cmp("mid_c2_S", S, 1);
      rst = 1;
      step(); cmp("mid_S", S, 0); cmp("mid_done", done, 0); cmp("mid_cnt", op_count, 0);
      rst = 0;
      step(); cmp("mid_ready", req_ready, 1); cmp("mid_done2", done, 0);

      // Back-to-back sets with valid held: counter wraps, accepts every P+SC+2 cycles
      req_valid = 1; req_op = 2'd1;
      n = 0;
      for (int i = 0; i < 9 * (P + SC + 2); i++) begin
         step();
         if (done) begin
            n++;
            cmp("wrap_cnt", op_count, n % (1 << CW));
         end
      end
      cmp("wrap_ops", n, 9);

      // Random traffic
      req_valid = 0;
      for (int i = 0; i < 4000; i++) begin
         rst       = ($urandom_range(0, 199) == 0);
         req_valid = ($urandom_range(0, 2) != 0);
         req_op    = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) q_fb = ~q_fb;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
